// File: rtl/target_codeblock_param.sv
// Parametrised target code block: a stutterable step machine running
// a loop of clamped array reads, with branching or select-based codegen.
module target_codeblock_param #(
  parameter int WIDTH      = 1,
  parameter int DEPTH      = 4,
  parameter int IDX_W      = 2,
  parameter int NUM_READS  = 2,
  parameter int BRANCHLESS = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stutter_in,
  input  logic [DEPTH*WIDTH-1:0]     arr,
  input  logic [IDX_W-1:0]           arr_size,
  input  logic [NUM_READS*IDX_W-1:0] idx,
  output logic [WIDTH-1:0]           a,
  output logic [WIDTH-1:0]           b,
  output logic [WIDTH-1:0]           acc,
  output logic                       stutter,
  output logic                       done,
  output logic [2:0]                 step,
  output logic [IDX_W:0]             iter
);

  localparam int IT_W = IDX_W + 1;
  localparam logic [IDX_W-1:0] DMAX = IDX_W'(DEPTH - 1);
  localparam logic [IT_W-1:0]  LAST = IT_W'(NUM_READS - 1);
  localparam logic [IT_W-1:0]  DLIM = IT_W'(DEPTH);

  typedef enum logic [2:0] {
    S_INIT       = 3'd0,
    S_LOAD_A     = 3'd1,
    S_CHECK      = 3'd2,
    S_READ_IN    = 3'd3,
    S_READ_CLAMP = 3'd4,
    S_NEXT       = 3'd5,
    S_HALT       = 3'd6,
    S_BAD        = 3'd7
  } step_t;

  step_t            step_q, step_n;
  logic [IT_W-1:0]  iter_q, iter_n;
  logic [WIDTH-1:0] a_q, a_n;
  logic [WIDTH-1:0] b_q, b_n;
  logic [WIDTH-1:0] acc_q, acc_n;
  logic             stutter_q;

  logic [IDX_W-1:0] eidx;
  logic [IDX_W-1:0] bnd;
  logic             in_rng;
  logic [WIDTH-1:0] v_in, v_cl, v_bl;

  // Entries past DEPTH read as zero rather than indexing out of range.
  function automatic logic [WIDTH-1:0] elem(
    input logic [DEPTH*WIDTH-1:0] ar,
    input logic [IDX_W-1:0]       k
  );
    logic [WIDTH-1:0] r;
    r = '0;
    for (int j = 0; j < DEPTH; j++) begin
      if (k == IDX_W'(j)) r = ar[j*WIDTH +: WIDTH];
    end
    return r;
  endfunction

  always_comb begin
    eidx = '0;
    for (int i = 0; i < NUM_READS; i++) begin
      if (iter_q == IT_W'(i)) eidx = idx[i*IDX_W +: IDX_W];
    end
  end

  assign bnd    = (arr_size < DMAX) ? arr_size : DMAX;
  assign in_rng = (eidx <= arr_size) && ({1'b0, eidx} < DLIM);
  assign v_in   = elem(arr, eidx);
  assign v_cl   = elem(arr, bnd);
  assign v_bl   = in_rng ? v_in : v_cl;

  always_comb begin
    step_n = step_q;
    iter_n = iter_q;
    a_n    = a_q;
    b_n    = b_q;
    acc_n  = acc_q;
    if (!stutter_in) begin
      case (step_q)
        S_INIT:   step_n = S_LOAD_A;
        S_LOAD_A: begin
          a_n    = elem(arr, '0);
          step_n = S_CHECK;
        end
        S_CHECK: begin
          if (BRANCHLESS != 0) begin
            b_n    = v_bl;
            acc_n  = acc_q ^ v_bl;
            step_n = S_NEXT;
          end else begin
            step_n = in_rng ? S_READ_IN : S_READ_CLAMP;
          end
        end
        S_READ_IN: begin
          b_n    = v_in;
          acc_n  = acc_q ^ v_in;
          step_n = S_NEXT;
        end
        S_READ_CLAMP: begin
          b_n    = v_cl;
          acc_n  = acc_q ^ v_cl;
          step_n = S_NEXT;
        end
        S_NEXT: begin
          if (iter_q == LAST) begin
            step_n = S_HALT;
          end else begin
            iter_n = iter_q + 1'b1;
            step_n = S_CHECK;
          end
        end
        S_HALT:  step_n = S_HALT;
        default: step_n = S_HALT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      step_q    <= S_INIT;
      iter_q    <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      stutter_q <= 1'b0;
    end else begin
      step_q    <= step_n;
      iter_q    <= iter_n;
      a_q       <= a_n;
      b_q       <= b_n;
      acc_q     <= acc_n;
      stutter_q <= stutter_in;
    end
  end

  assign a       = a_q;
  assign b       = b_q;
  assign acc     = acc_q;
  assign stutter = stutter_q;
  assign done    = (step_q == S_HALT);
  assign step    = step_q;
  assign iter    = iter_q;

endmodule

// File: tb/tb_target_codeblock_param.sv
// Directed bench for target_codeblock_param: branching, branchless and
// DEPTH=3 clamp instances driven through the listed scenarios.
module tb_target_codeblock_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       stutter_in;
  logic [3:0] arr;
  logic [1:0] arr_size;
  logic [3:0] idx;
  logic [2:0] arr2;
  logic [1:0] size2;
  logic [1:0] idx2;

  logic       a0, b0, acc0, st0, done0;
  logic [2:0] step0, iter0;
  logic       a1, b1, acc1, st1, done1;
  logic [2:0] step1, iter1;
  logic       a2, b2, acc2, st2, done2;
  logic [2:0] step2, iter2;

  int errors = 0;
  int checks = 0;

  target_codeblock_param u0 (
    .clk(clk), .rst(rst), .stutter_in(stutter_in),
    .arr(arr), .arr_size(arr_size), .idx(idx),
    .a(a0), .b(b0), .acc(acc0), .stutter(st0),
    .done(done0), .step(step0), .iter(iter0)
  );

  target_codeblock_param #(.BRANCHLESS(1)) u1 (
    .clk(clk), .rst(rst), .stutter_in(stutter_in),
    .arr(arr), .arr_size(arr_size), .idx(idx),
    .a(a1), .b(b1), .acc(acc1), .stutter(st1),
    .done(done1), .step(step1), .iter(iter1)
  );

  target_codeblock_param #(.DEPTH(3), .NUM_READS(1)) u2 (
    .clk(clk), .rst(rst), .stutter_in(stutter_in),
    .arr(arr2), .arr_size(size2), .idx(idx2),
    .a(a2), .b(b2), .acc(acc2), .stutter(st2),
    .done(done2), .step(step2), .iter(iter2)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    stutter_in = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic set_s1;
    arr = 4'b1010;
    arr_size = 2'd1;
    idx = 4'b1101;
  endtask

  task automatic test_reset;
    set_s1();
    arr2 = 3'b100; size2 = 2'd3; idx2 = 2'd3;
    rst = 1'b1;
    stutter_in = 1'b1;
    tick();
    checks++;
    if ({step0, iter0, a0, b0, acc0, st0, done0} !== 11'd0) begin
      errors++;
      $display("FAIL reset_u0 got %b want 0", {step0, iter0, a0, b0, acc0, st0, done0});
    end
    checks++;
    if ({step1, iter1, a1, b1, acc1, st1, done1} !== 11'd0) begin
      errors++;
      $display("FAIL reset_u1 got %b want 0", {step1, iter1, a1, b1, acc1, st1, done1});
    end
    checks++;
    if ({step2, iter2, a2, b2, acc2, st2, done2} !== 11'd0) begin
      errors++;
      $display("FAIL reset_u2 got %b want 0", {step2, iter2, a2, b2, acc2, st2, done2});
    end
    rst = 1'b0;
    stutter_in = 1'b0;
  endtask

  task automatic test_branching;
    int e0[9] = '{0, 1, 2, 3, 5, 2, 4, 5, 6};
    int e1[9] = '{0, 1, 2, 5, 2, 5, 6, 6, 6};
    set_s1();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      if (i > 0) tick();
      checks++;
      if (step0 !== 3'(e0[i]) || done0 !== (i == 8)) begin
        errors++;
        $display("FAIL seq_branch edge%0d got step=%0d done=%b want step=%0d done=%b",
                 i, step0, done0, e0[i], (i == 8));
      end
      checks++;
      if (step1 !== 3'(e1[i]) || done1 !== (i >= 6)) begin
        errors++;
        $display("FAIL seq_branchless edge%0d got step=%0d done=%b want step=%0d done=%b",
                 i, step1, done1, e1[i], (i >= 6));
      end
    end
    checks++;
    if ({a0, b0, acc0} !== 3'b010) begin
      errors++;
      $display("FAIL res_branch got a,b,acc=%b want 010", {a0, b0, acc0});
    end
    checks++;
    if ({a1, b1, acc1} !== 3'b010) begin
      errors++;
      $display("FAIL res_branchless got a,b,acc=%b want 010", {a1, b1, acc1});
    end
  endtask

  task automatic test_stutter;
    set_s1();
    do_reset();
    repeat (5) tick();
    checks++;
    if (step0 !== 3'd2 || iter0 !== 3'd1) begin
      errors++;
      $display("FAIL stut_pre got step=%0d iter=%0d want 2 1", step0, iter0);
    end
    stutter_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({step0, iter0, b0, acc0, st0} !== {3'd2, 3'd1, 1'b1, 1'b1, 1'b1}) begin
        errors++;
        $display("FAIL stut_hold cyc%0d got step=%0d iter=%0d b=%b acc=%b st=%b want 2 1 1 1 1",
                 i, step0, iter0, b0, acc0, st0);
      end
    end
    stutter_in = 1'b0;
    tick();
    checks++;
    if (st0 !== 1'b0 || step0 !== 3'd4) begin
      errors++;
      $display("FAIL stut_release got st=%b step=%0d want 0 4", st0, step0);
    end
    tick();
    checks++;
    if (done0 !== 1'b0) begin
      errors++;
      $display("FAIL stut_done10 got %b want 0", done0);
    end
    tick();
    checks++;
    if (done0 !== 1'b1 || {a0, b0, acc0} !== 3'b010) begin
      errors++;
      $display("FAIL stut_done11 got done=%b abacc=%b want 1 010", done0, {a0, b0, acc0});
    end
  endtask

  task automatic test_in_range;
    arr = 4'b1000;
    arr_size = 2'd3;
    idx = 4'b0011;
    do_reset();
    repeat (3) tick();
    checks++;
    if (step0 !== 3'd3) begin
      errors++;
      $display("FAIL inr_read0 got step=%0d want 3", step0);
    end
    repeat (3) tick();
    checks++;
    if (step0 !== 3'd3) begin
      errors++;
      $display("FAIL inr_read1 got step=%0d want 3", step0);
    end
    repeat (2) tick();
    checks++;
    if ({done0, a0, b0, acc0} !== 4'b1001) begin
      errors++;
      $display("FAIL inr_res got done,a,b,acc=%b want 1001", {done0, a0, b0, acc0});
    end
    checks++;
    if ({done1, a1, b1, acc1} !== 4'b1001) begin
      errors++;
      $display("FAIL inr_res_bl got done,a,b,acc=%b want 1001", {done1, a1, b1, acc1});
    end
  endtask

  task automatic test_clamp_depth3;
    int e2[6] = '{0, 1, 2, 4, 5, 6};
    arr2 = 3'b100;
    size2 = 2'd3;
    idx2 = 2'd3;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick();
      checks++;
      if (step2 !== 3'(e2[i])) begin
        errors++;
        $display("FAIL d3_seq edge%0d got step=%0d want %0d", i, step2, e2[i]);
      end
    end
    checks++;
    if ({done2, a2, b2, acc2} !== 4'b1011) begin
      errors++;
      $display("FAIL d3_res got done,a,b,acc=%b want 1011", {done2, a2, b2, acc2});
    end
  endtask

  task automatic test_reset_mid;
    set_s1();
    do_reset();
    repeat (4) tick();
    checks++;
    if (step0 !== 3'd5 || iter0 !== 3'd0) begin
      errors++;
      $display("FAIL mid_pre got step=%0d iter=%0d want 5 0", step0, iter0);
    end
    rst = 1'b1;
    stutter_in = 1'b1;
    tick();
    checks++;
    if ({step0, iter0, a0, b0, acc0, st0, done0} !== 11'd0) begin
      errors++;
      $display("FAIL mid_rst got %b want 0", {step0, iter0, a0, b0, acc0, st0, done0});
    end
    rst = 1'b0;
    stutter_in = 1'b0;
    repeat (8) tick();
    checks++;
    if ({done0, a0, b0, acc0} !== 4'b1010) begin
      errors++;
      $display("FAIL mid_rerun got done,a,b,acc=%b want 1010", {done0, a0, b0, acc0});
    end
    rst = 1'b1;
    stutter_in = 1'b1;
    tick();
    checks++;
    if ({step0, iter0, a0, b0, acc0, st0, done0} !== 11'd0) begin
      errors++;
      $display("FAIL halt_rst got %b want 0", {step0, iter0, a0, b0, acc0, st0, done0});
    end
    rst = 1'b0;
    stutter_in = 1'b0;
    repeat (8) tick();
    checks++;
    if ({done0, a0, b0, acc0} !== 4'b1010) begin
      errors++;
      $display("FAIL halt_rerun got done,a,b,acc=%b want 1010", {done0, a0, b0, acc0});
    end
  endtask

  initial begin
    rst = 1'b1;
    stutter_in = 1'b0;
    arr = '0; arr_size = '0; idx = '0;
    arr2 = '0; size2 = '0; idx2 = '0;
    test_reset();
    test_branching();
    test_stutter();
    test_in_range();
    test_clamp_depth3();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/target_codeblock_param.md
Name: target_codeblock_param

Overview:
Parametrised successor of the single-access target code block used in the compiler-optimisation case studies. It models a compiled program as a stutterable step machine. The program loads arr[0] into a, then runs a loop of NUM_READS bounds-checked array reads, with each index clamped to arr_size. The last read goes to b and the XOR of all reads goes to acc. It serves as the "target" side of asynchronous HyperLTL comparisons, so the step count per mode is part of the observable behaviour.

Parameters:
WIDTH, 1, bit width of one array element and of a, b, acc
DEPTH, 4, number of array entries
IDX_W, 2, width of indices and arr_size; DEPTH <= 2**IDX_W
NUM_READS, 2, loop iterations (>=1)
BRANCHLESS, 0, 0 = branching codegen (separate in-range and clamp steps); 1 = select-based codegen (one step per read)

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous active-high reset
stutter_in  in  1  1 = freeze the program for this cycle
arr  in  DEPTH*WIDTH  array; entry k is arr[k*WIDTH +: WIDTH]
arr_size  in  IDX_W  bound for clamping (unsigned)
idx  in  NUM_READS*IDX_W  loop indices; index i is idx[i*IDX_W +: IDX_W]
a  out  WIDTH  arr[0], loaded at step LOAD_A
b  out  WIDTH  value of the most recent read
acc  out  WIDTH  XOR of all reads so far
stutter  out  1  registered copy of stutter_in
done  out  1  high while in HALT
step  out  3  current program step (encoding below)
iter  out  IDX_W+1 (min 1)  current loop iteration counter

Behaviour:
- Reset (rst=1 at posedge): step=INIT, and iter, a, b, acc, stutter and done all become 0. Reset dominates stutter_in. Reset mid-program or in HALT restarts from INIT.
- Every non-reset posedge: stutter <= stutter_in.
- If stutter_in=1: step, iter, a, b, acc and done hold their values.
- Inputs are sampled only in the step that uses them and are not latched. The effective index is eidx = idx[iter] (unsigned). The effective bound is bnd = min(arr_size, DEPTH-1).
- Step encodings: INIT=0, LOAD_A=1, CHECK=2, READ_IN=3, READ_CLAMP=4, NEXT=5, HALT=6. Encoding 7 is unreachable; if it is ever reached, go to HALT.
- INIT -> LOAD_A.
- LOAD_A: a <= arr[0]; go to CHECK.
- CHECK with BRANCHLESS=0: if eidx <= arr_size and eidx < DEPTH, go to READ_IN; else go to READ_CLAMP. No data update.
- CHECK with BRANCHLESS=1: v = (eidx <= bnd) ? arr[eidx] : arr[bnd]; b <= v; acc <= acc ^ v; go to NEXT. READ_IN and READ_CLAMP are never entered.
- READ_IN: v = arr[eidx]; b <= v; acc <= acc ^ v; go to NEXT.
- READ_CLAMP: v = arr[bnd]; b <= v; acc <= acc ^ v; go to NEXT.
- NEXT: if iter == NUM_READS-1, go to HALT; else iter <= iter+1 and go to CHECK.
- HALT: done=1. Hold HALT and all outputs until reset.
- Latency from rst deassert to done=1, with no stutter: 2+3*NUM_READS edges when BRANCHLESS=0, 2+2*NUM_READS edges when BRANCHLESS=1. Each stutter cycle adds exactly one edge.
- Functional results are identical across modes for the same inputs; only the timing differs.
- done is driven from the state register, not from a separate flag, so no glitch is possible.

Test Plan:
1. Defaults (WIDTH=1, DEPTH=4, NUM_READS=2, BRANCHLESS=0); arr=4'b1010, arr_size=1, idx[0]=1, idx[1]=3; no stutter -> step sequence 0,1,2,3,5,2,4,5,6. a=0, b=1, acc=0. done rises exactly 8 edges after reset release.
2. Same stimulus with BRANCHLESS=1 -> step sequence 0,1,2,5,2,5,6. a=0, b=1, acc=0. done rises 6 edges after reset release.
3. Default config, stutter_in=1 for 3 cycles while in CHECK of iteration 1 -> step, iter, b and acc frozen during those cycles. stutter follows stutter_in one cycle late. done rises at edge 11. Final values are the same as scenario 1.
4. Default config, arr=4'b1000, arr_size=3, idx[0]=3, idx[1]=0 -> both reads in range (steps 3,3). b=0, acc=1, a=0.
5. DEPTH=3, IDX_W=2, arr=3'b100, arr_size=3, idx[0]=3 -> CHECK goes to READ_CLAMP with bnd=2, so b=1. There is no out-of-bounds access.
6. rst asserted in NEXT of iteration 0, or in HALT, together with stutter_in=1 -> next edge gives step=0 and all outputs 0. A full rerun then completes with the same results as scenario 1.
